mealy_stream_arbiter: RTL and testbench

//   Round-robin arbiter that shares one serial Mealy pattern detector (ain -> yout) among NREQ requesters.

---
 rtl/mealy_arb_pkg.sv | 16 +
 rtl/rr_arbiter_pick.sv | 29 ++
 rtl/mealy_stream_arbiter.sv | 130 +++++++++++++
 tb/tb_mealy_stream_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mealy_arb_pkg.sv
// Shared constants for the Mealy stream arbiter: FSM state encoding and default sizing.
package mealy_arb_pkg;

   typedef logic [1:0] state_t;

   localparam state_t StIdle   = 2'd0;
   localparam state_t StClear  = 2'd1;
   localparam state_t StShift  = 2'd2;
   localparam state_t StReport = 2'd3;

   localparam int unsigned DefNreq     = 4;
   localparam int unsigned DefFrameLen = 16;
   localparam int unsigned DefCntW     = 5;
   localparam int unsigned DefIdW      = 2;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin picker: first set request after last_id, wrapping modulo NREQ.
module rr_arbiter_pick #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned ID_W = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] last_id,
   output logic            any,
   output logic [ID_W-1:0] id
);

   always_comb begin
      logic            found;
      logic [ID_W-1:0] idx;
      found = 1'b0;
      idx   = '0;
      any   = |req;
      id    = '0;
      // Offset 1 first so the previous winner has the lowest priority.
      for (int unsigned off = 1; off <= NREQ; off++) begin
         idx = ID_W'((32'(last_id) + off) % NREQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            id    = idx;
         end
      end
   end

endmodule

// File: rtl/mealy_stream_arbiter.sv
// Round-robin arbiter sharing one serial Mealy detector: serialises the granted frame MSB-first
// and reports how many detector pulses it produced.
module mealy_stream_arbiter
   import mealy_arb_pkg::*;
#(
   parameter int unsigned NREQ      = DefNreq,
   parameter int unsigned FRAME_LEN = DefFrameLen,
   parameter int unsigned CNT_W     = DefCntW,
   parameter int unsigned ID_W      = DefIdW
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*FRAME_LEN-1:0] frame,
   output logic [NREQ-1:0]           grant,
   output logic                      busy,
   output logic                      done,
   output logic [ID_W-1:0]           done_id,
   output logic [CNT_W-1:0]          match_cnt,
   output logic                      det_reset,
   output logic                      det_ain,
   input  logic                      det_yout
);

   localparam int unsigned BitW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   state_t                 state_q, state_d;
   logic [FRAME_LEN-1:0]   sreg_q, sreg_d;
   logic [BitW-1:0]        bit_q, bit_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
   logic [ID_W-1:0]        last_id_q, last_id_d;
   logic [ID_W-1:0]        done_id_q, done_id_d;
   logic [CNT_W-1:0]       match_q, match_d;

   logic                   pick_any;
   logic [ID_W-1:0]        pick_id;

   rr_arbiter_pick #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_pick (
      .req     (req),
      .last_id (last_id_q),
      .any     (pick_any),
      .id      (pick_id)
   );

   // det_yout is a same-cycle function of det_ain, so it is folded in before the edge.
   assign cnt_inc = cnt_q + CNT_W'(det_yout);

   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      bit_d     = bit_q;
      cnt_d     = cnt_q;
      last_id_d = last_id_q;
      done_id_d = done_id_q;
      match_d   = match_q;
      unique case (state_q)
         StIdle: begin
            if (pick_any) begin
               sreg_d    = frame[32'(pick_id) * FRAME_LEN +: FRAME_LEN];
               last_id_d = pick_id;
               state_d   = StClear;
            end
         end
         StClear: begin
            bit_d   = '0;
            cnt_d   = '0;
            state_d = StShift;
         end
         StShift: begin
            sreg_d = sreg_q << 1;
            cnt_d  = cnt_inc;
            bit_d  = bit_q + 1'b1;
            if (bit_q == BitW'(FRAME_LEN - 1)) begin
               match_d   = cnt_inc;
               done_id_d = last_id_q;
               state_d   = StReport;
            end
         end
         StReport: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StIdle;
         sreg_q    <= '0;
         bit_q     <= '0;
         cnt_q     <= '0;
         last_id_q <= ID_W'(NREQ - 1);
         done_id_q <= '0;
         match_q   <= '0;
      end else begin
         state_q   <= state_d;
         sreg_q    <= sreg_d;
         bit_q     <= bit_d;
         cnt_q     <= cnt_d;
         last_id_q <= last_id_d;
         done_id_q <= done_id_d;
         match_q   <= match_d;
      end
   end

   // Grant is decoded from the served index, so it is one-hot by construction.
   always_comb begin
      grant = '0;
      if (state_q == StClear || state_q == StShift) begin
         grant[last_id_q] = 1'b1;
      end
   end

   assign busy      = (state_q != StIdle);
   assign done      = reset && (state_q == StReport);
   assign done_id   = done_id_q;
   assign match_cnt = match_q;
   assign det_reset = !reset || (state_q == StClear);
   assign det_ain   = reset && (state_q == StShift) && sreg_q[FRAME_LEN-1];

   grant_onehot_a : assert property (@(posedge clk) disable iff (!reset) $onehot0(grant));
   match_range_a  : assert property (@(posedge clk) disable iff (!reset)
                                     !(match_q > CNT_W'(FRAME_LEN)));

endmodule

// File: tb/tb_mealy_stream_arbiter.sv
// Self-checking bench for mealy_stream_arbiter with a pass-through detector stub.
module tb_mealy_stream_arbiter;

   localparam int NREQ  = 4;
   localparam int FL    = 16;
   localparam int CNT_W = 5;
   localparam int ID_W  = 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      req;
   logic [NREQ*FL-1:0]   frame;
   logic [NREQ-1:0]      grant;
   logic                 busy;
   logic                 done;
   logic [ID_W-1:0]      done_id;
   logic [CNT_W-1:0]     match_cnt;
   logic                 det_reset;
   logic                 det_ain;
   logic                 det_yout;

   assign det_yout = det_ain;

   always #5 clk = ~clk;

   mealy_stream_arbiter #(
      .NREQ      (NREQ),
      .FRAME_LEN (FL),
      .CNT_W     (CNT_W),
      .ID_W      (ID_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .frame     (frame),
      .grant     (grant),
      .busy      (busy),
      .done      (done),
      .done_id   (done_id),
      .match_cnt (match_cnt),
      .det_reset (det_reset),
      .det_ain   (det_ain),
      .det_yout  (det_yout)
   );

   logic [14:0] dut_vec;
   assign dut_vec = {grant, busy, done, done_id, match_cnt, det_reset, det_ain};

   int checks     = 0;
   int failures   = 0;
   int cyc        = 0;
   int g_cyc      = 0;
   int done_count = 0;
   bit gprev      = 1'b0;

   // Reference model: m_p counts cycles since the grant edge (0 = idle).
   int          m_p       = 0;
   int          m_last    = NREQ - 1;
   int          m_cur     = 0;
   logic [FL-1:0] m_word  = '0;
   int          m_done_id = 0;
   int          m_match   = 0;

   typedef struct {
      logic [NREQ-1:0]    req;
      logic [NREQ*FL-1:0] frames;
      int                 exp_id;
      int                 exp_cnt;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic model_step();
      bit found;
      found = 1'b0;
      if (!reset) begin
         m_p = 0; m_last = NREQ - 1; m_cur = 0; m_word = '0; m_done_id = 0; m_match = 0;
      end else if (m_p == 0) begin
         for (int off = 1; off <= NREQ; off++) begin
            if (!found && req[(m_last + off) % NREQ]) begin
               found  = 1'b1;
               m_cur  = (m_last + off) % NREQ;
            end
         end
         if (found) begin
            m_last = m_cur;
            m_word = frame[m_cur*FL +: FL];
            m_p    = 1;
         end
      end else if (m_p <= FL) begin
         m_p++;
      end else if (m_p == FL + 1) begin
         m_p       = FL + 2;
         m_done_id = m_cur;
         m_match   = $countones(m_word);
      end else begin
         m_p = 0;
      end
   endtask

   function automatic logic [14:0] model_out();
      logic [NREQ-1:0] g;
      logic            ain;
      logic [FL-1:0]   w;
      g   = '0;
      ain = 1'b0;
      w   = m_word;
      if (m_p >= 1 && m_p <= FL + 1) g = NREQ'(1 << m_cur);
      if (reset && m_p >= 2 && m_p <= FL + 1) ain = w[4'(FL + 1 - m_p)];
      return {g, (m_p != 0), (reset && m_p == FL + 2), ID_W'(m_done_id), CNT_W'(m_match),
              (!reset || m_p == 1), ain};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
      check("cycle_outputs", 64'(dut_vec), 64'(model_out()));
      if (done === 1'b1) done_count++;
      if (grant != '0 && !gprev) g_cyc = cyc;
      gprev = (grant != '0);
   endtask

   task automatic wait_done(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (done === 1'b1) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic wait_grant(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (grant != '0) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   initial begin
      bit ok;
      int base;
      int exp_order[5];

      vecs[0] = '{4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'hA5A5}, 0, 8};
      vecs[1] = '{4'b0100, {16'h0000, 16'hFFFF, 16'h0000, 16'h0000}, 2, 16};
      vecs[2] = '{4'b0101, {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, 0, 16};
      vecs[3] = '{4'b0101, {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, 2, 0};
      vecs[4] = '{4'b1010, {16'h8000, 16'h0000, 16'h0001, 16'h0000}, 3, 1};
      vecs[5] = '{4'b1010, {16'h8000, 16'h0000, 16'h0001, 16'h0000}, 1, 1};
      vecs[6] = '{4'b0011, {16'h0000, 16'h0000, 16'h1234, 16'h00F0}, 0, 4};
      vecs[7] = '{4'b1000, {16'h7FFE, 16'h0000, 16'h0000, 16'h0000}, 3, 14};

      reset = 1'b0;
      req   = '0;
      frame = '0;
      repeat (3) tick();
      check("reset_grant", 64'(grant), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      check("reset_det_reset", 64'(det_reset), 64'(1));
      check("reset_det_ain", 64'(det_ain), 64'(0));
      check("reset_match_cnt", 64'(match_cnt), 64'(0));
      reset = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         req   = vecs[i].req;
         frame = vecs[i].frames;
         wait_done(60, ok);
         check($sformatf("vec%0d_done_seen", i), 64'(ok), 64'(1));
         check($sformatf("vec%0d_done_id", i), 64'(done_id), 64'(vecs[i].exp_id));
         check($sformatf("vec%0d_match_cnt", i), 64'(match_cnt), 64'(vecs[i].exp_cnt));
         check($sformatf("vec%0d_latency", i), 64'(cyc - g_cyc), 64'(FL + 1));
      end

      // All four requesting continuously: strict rotation from the last winner (id 3).
      exp_order = '{0, 1, 2, 3, 0};
      req   = 4'b1111;
      frame = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      for (int k = 0; k < 5; k++) begin
         wait_done(60, ok);
         check($sformatf("rot%0d_done_seen", k), 64'(ok), 64'(1));
         check($sformatf("rot%0d_done_id", k), 64'(done_id), 64'(exp_order[k]));
      end

      // Drop req and change frame on shift bit 3: latched word still completes.
      req   = 4'b0001;
      frame = {16'h0000, 16'h0000, 16'h0000, 16'hC3C3};
      wait_grant(20, ok);
      check("drop_grant_seen", 64'(ok), 64'(1));
      repeat (4) tick();
      req   = 4'b0000;
      frame = {16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
      wait_done(40, ok);
      check("drop_done_seen", 64'(ok), 64'(1));
      check("drop_done_id", 64'(done_id), 64'(0));
      check("drop_match_cnt", 64'(match_cnt), 64'(8));
      repeat (3) tick();
      check("drop_no_regrant", 64'(busy), 64'(0));

      // Reset on shift bit 7 loses the frame; a fresh one runs after release.
      req   = 4'b0001;
      frame = {16'h0000, 16'h0000, 16'h0000, 16'h0F0F};
      wait_grant(20, ok);
      check("rst_grant_seen", 64'(ok), 64'(1));
      repeat (8) tick();
      base  = done_count;
      reset = 1'b0;
      tick();
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_grant", 64'(grant), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      tick();
      reset = 1'b1;
      wait_done(40, ok);
      check("rst_done_seen", 64'(ok), 64'(1));
      check("rst_done_id", 64'(done_id), 64'(0));
      check("rst_match_cnt", 64'(match_cnt), 64'(8));
      check("rst_single_done", 64'(done_count - base), 64'(1));
      req = '0;
      repeat (2) tick();

      // Randomised traffic against the model.
      base = done_count;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) req = NREQ'($urandom_range(0, 15));
         frame = {$urandom, $urandom};
         reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         tick();
      end
      check("random_activity", 64'(done_count > base), 64'(1));
      reset = 1'b1;
      req   = '0;
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
